// File: rtl/block_buffer_loader.sv
// Ping-pong block-buffer loader: fetches one BLOCK_SIZE x BLOCK_SIZE block per channel
// from single-port frame BRAMs into two banks, with handshake, release and zero-fill.
module block_buffer_loader #(
  parameter int NUM_CH       = 2,
  parameter int BLOCK_SIZE   = 6,
  parameter int PIXEL_W      = 8,
  parameter int IMG_W        = 240,
  parameter int IMG_H        = 320,
  parameter int BRAM_LATENCY = 2,
  localparam int WORD_W        = BLOCK_SIZE * PIXEL_W,
  localparam int WORDS_PER_ROW = IMG_W / BLOCK_SIZE,
  localparam int XW            = $clog2(WORDS_PER_ROW) + 1,
  localparam int YW            = $clog2(IMG_H) + 1,
  localparam int AW            = $clog2(WORDS_PER_ROW * IMG_H)
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                valid_in,
  output logic                                ready_out,
  input  logic [NUM_CH*XW-1:0]                cur_x,
  input  logic [NUM_CH*YW-1:0]                cur_y,
  input  logic [NUM_CH*WORD_W-1:0]            bram_dout,
  output logic [NUM_CH*AW-1:0]                bram_addr,
  output logic [NUM_CH*BLOCK_SIZE*WORD_W-1:0] bank0_out,
  output logic [NUM_CH*BLOCK_SIZE*WORD_W-1:0] bank1_out,
  output logic [1:0]                          bank_valid,
  input  logic [1:0]                          release_in,
  output logic                                done_out,
  output logic                                done_bank
);

  localparam int RW     = $clog2(BLOCK_SIZE + 1);
  localparam int DW     = $clog2(BRAM_LATENCY + 1);
  localparam int SW     = AW + YW;
  localparam int BANK_W = NUM_CH * BLOCK_SIZE * WORD_W;

  if (IMG_W % BLOCK_SIZE != 0) begin : g_width_check
    $error("IMG_W must be an integer multiple of BLOCK_SIZE");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [XW-1:0]       r_x [NUM_CH];
  logic [YW-1:0]       r_y [NUM_CH];
  logic [RW-1:0]       r_row;
  logic [DW-1:0]       r_drain;
  logic                r_tgt;
  logic                r_any_done;
  logic [NUM_CH*AW-1:0] r_addr;
  logic                r_iss_valid;
  logic [RW-1:0]       r_iss_row;
  logic [NUM_CH-1:0]   r_iss_inr;
  logic                r_dl_valid [BRAM_LATENCY];
  logic [RW-1:0]       r_dl_row   [BRAM_LATENCY];
  logic [NUM_CH-1:0]   r_dl_inr   [BRAM_LATENCY];
  logic [BANK_W-1:0]   r_bank0;
  logic [BANK_W-1:0]   r_bank1;
  logic [1:0]          r_bank_valid;
  logic                r_done;
  logic                r_done_bank;

  logic                w_accept;
  logic                w_issue_more;
  logic                w_complete;
  logic                w_tgt_sel;
  logic [RW-1:0]       w_rs;
  logic [NUM_CH-1:0]   w_inr;
  logic [NUM_CH*AW-1:0] w_addr;

  assign ready_out  = (r_state == S_IDLE) && (r_bank_valid != 2'b11);
  assign bram_addr  = r_addr;
  assign bank0_out  = r_bank0;
  assign bank1_out  = r_bank1;
  assign bank_valid = r_bank_valid;
  assign done_out   = r_done;
  assign done_bank  = r_done_bank;

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and sequencing strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_issue_more = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (valid_in && ready_out) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (r_row == RW'(BLOCK_SIZE - 1)) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_issue_more = 1'b1;
          w_state_nxt  = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (r_drain == DW'(BRAM_LATENCY - 1)) begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Target bank: the free one; with both free alternate, starting at bank 0 after reset
  always_comb begin
    w_tgt_sel = 1'b0;
    if (r_bank_valid == 2'b00) begin
      w_tgt_sel = r_any_done ? ~r_done_bank : 1'b0;
    end else if (!r_bank_valid[0]) begin
      w_tgt_sel = 1'b0;
    end else begin
      w_tgt_sel = 1'b1;
    end
  end

  // The address registered this edge is for row 0 on accept, else the row after r_row
  assign w_rs = (r_state == S_IDLE) ? '0 : RW'(r_row + RW'(1));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [XW-1:0] w_xs;
    logic [YW-1:0] w_ys;
    logic [SW-1:0] w_rowsum;
    assign w_xs      = (r_state == S_IDLE) ? cur_x[c*XW +: XW] : r_x[c];
    assign w_ys      = (r_state == S_IDLE) ? cur_y[c*YW +: YW] : r_y[c];
    assign w_rowsum  = SW'(w_ys) + SW'(w_rs);
    assign w_inr[c]  = (w_rowsum < SW'(IMG_H)) && (w_xs < XW'(WORDS_PER_ROW));
    assign w_addr[c*AW +: AW] = w_inr[c] ?
                                AW'(w_rowsum * SW'(WORDS_PER_ROW) + SW'(w_xs)) : '0;
  end

  // Request latch, address issue, capture-tag delay line and bank bookkeeping
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_x[c] <= '0;
        r_y[c] <= '0;
      end
      r_row        <= '0;
      r_drain      <= '0;
      r_tgt        <= 1'b0;
      r_any_done   <= 1'b0;
      r_addr       <= '0;
      r_iss_valid  <= 1'b0;
      r_iss_row    <= '0;
      r_iss_inr    <= '0;
      for (int k = 0; k < BRAM_LATENCY; k++) begin
        r_dl_valid[k] <= 1'b0;
        r_dl_row[k]   <= '0;
        r_dl_inr[k]   <= '0;
      end
      r_bank_valid <= 2'b00;
      r_done       <= 1'b0;
      r_done_bank  <= 1'b0;
    end else begin
      if (w_accept) begin
        for (int c = 0; c < NUM_CH; c++) begin
          r_x[c] <= cur_x[c*XW +: XW];
          r_y[c] <= cur_y[c*YW +: YW];
        end
        r_tgt <= w_tgt_sel;
        r_row <= '0;
      end else if (w_issue_more) begin
        r_row <= RW'(r_row + RW'(1));
      end
      r_drain     <= (r_state == S_DRAIN) ? DW'(r_drain + DW'(1)) : '0;
      r_addr      <= (w_accept || w_issue_more) ? w_addr : '0;
      r_iss_valid <= w_accept || w_issue_more;
      r_iss_row   <= w_rs;
      r_iss_inr   <= w_inr;
      r_dl_valid[0] <= r_iss_valid;
      r_dl_row[0]   <= r_iss_row;
      r_dl_inr[0]   <= r_iss_inr;
      for (int k = 1; k < BRAM_LATENCY; k++) begin
        r_dl_valid[k] <= r_dl_valid[k-1];
        r_dl_row[k]   <= r_dl_row[k-1];
        r_dl_inr[k]   <= r_dl_inr[k-1];
      end
      // Completion of a bank outranks a same-edge release of that bank
      for (int b = 0; b < 2; b++) begin
        if (w_complete && (r_tgt == b[0])) begin
          r_bank_valid[b] <= 1'b1;
        end else if (release_in[b]) begin
          r_bank_valid[b] <= 1'b0;
        end
      end
      r_done <= w_complete;
      if (w_complete) begin
        r_done_bank <= r_tgt;
        r_any_done  <= 1'b1;
      end
    end
  end

  // Row capture into the target bank; out-of-range rows are written as zero
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_bank0 <= '0;
      r_bank1 <= '0;
    end else if (r_dl_valid[BRAM_LATENCY-1]) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (r_tgt == 1'b0) begin
          r_bank0[(c*BLOCK_SIZE + int'(r_dl_row[BRAM_LATENCY-1]))*WORD_W +: WORD_W] <=
            r_dl_inr[BRAM_LATENCY-1][c] ? bram_dout[c*WORD_W +: WORD_W] : '0;
        end else begin
          r_bank1[(c*BLOCK_SIZE + int'(r_dl_row[BRAM_LATENCY-1]))*WORD_W +: WORD_W] <=
            r_dl_inr[BRAM_LATENCY-1][c] ? bram_dout[c*WORD_W +: WORD_W] : '0;
        end
      end
    end
  end

endmodule

// File: doc/block_buffer_loader.md
Name: block_buffer_loader

Overview:
- Parametrised successor to the stereo left/right block-buffer updater.
- Fetches one BLOCK_SIZE x BLOCK_SIZE pixel block per channel from per-channel single-port frame BRAMs (one BRAM word = one block row) into ping-pong banks.
- Adds ready/valid handshake, automatic free-bank selection, per-bank ownership with consumer release, and zero-fill for rows/columns outside the image.
- Sits between the frame BRAMs and the disparity/SAD matcher; N channels (default 2 = left/right).

Parameters:
NUM_CH, 2, number of image channels fetched in lockstep
BLOCK_SIZE, 6, pixels per block edge = BRAM words read per block
PIXEL_W, 8, bits per pixel; WORD_W = BLOCK_SIZE*PIXEL_W
IMG_W, 240, image width in pixels; WORDS_PER_ROW = IMG_W/BLOCK_SIZE (integer, checked at elaboration)
IMG_H, 320, image height in rows
BRAM_LATENCY, 2, read latency in cycles from address to dout (2 = HIGH_PERFORMANCE, 1 = LOW_LATENCY)
Derived: XW=$clog2(WORDS_PER_ROW)+1, YW=$clog2(IMG_H)+1, AW=$clog2(WORDS_PER_ROW*IMG_H)

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset; asynchronous, active-high
valid_in  in  1  request strobe
ready_out  out  1  block can accept a request
cur_x  in  NUM_CH*XW  per-channel block column (word index)
cur_y  in  NUM_CH*YW  per-channel top pixel row
bram_dout  in  NUM_CH*WORD_W  per-channel BRAM read data
bram_addr  out  NUM_CH*AW  per-channel BRAM read address, registered
bank0_out  out  NUM_CH*BLOCK_SIZE*WORD_W  bank 0 contents, row r of ch c at [(c*BLOCK_SIZE+r)*WORD_W +: WORD_W]
bank1_out  out  same  bank 1 contents
bank_valid  out  2  bank b holds a complete, unreleased block
release_in  in  2  consumer frees bank b (1-cycle pulse)
done_out  out  1  1-cycle pulse on block completion
done_bank  out  1  bank index just completed

Behaviour:
- Reset (async, any state): state IDLE, bank_valid=0, done_out=0, done_bank=0, bram_addr=0, both banks all-zero, row/capture counters 0; ready_out=1 in first cycle after deassertion. Reset mid-fetch abandons the fetch; no done_out.
- ready_out = (state==IDLE) && (bank_valid != 2'b11).
- Accept: valid_in && ready_out at edge T; latch cur_x/cur_y for all channels; target bank = the non-valid bank; if both free, the bank != done_bank (strict alternation). valid_in while !ready_out is ignored (no queue).
- States: IDLE -> ISSUE (BLOCK_SIZE cycles, row r=0..BLOCK_SIZE-1) -> DRAIN (BRAM_LATENCY cycles) -> IDLE.
- ISSUE row r: bram_addr[c] = (y_c+r)*WORDS_PER_ROW + x_c, presented in cycle T+1+r.
- Out-of-range row (y_c+r >= IMG_H) or column (x_c >= WORDS_PER_ROW): bram_addr[c]=0, row tagged invalid; captured row written as all-zero.
- Capture: delay line of depth BRAM_LATENCY carries {row_valid, r, inrange_c}; bram_dout[c] written to target bank row r at edge ending cycle T+1+r+BRAM_LATENCY.
- Completion: last row written at edge ending cycle T+BLOCK_SIZE+BRAM_LATENCY; at that edge bank_valid[target]<=1, done_out<=1 for exactly one cycle, done_bank<=target, state<=IDLE. Defaults (6,2): accept edge 0, done_out high in cycle 9, next accept possible in cycle 9.
- Bank not being filled is never modified; filling bank is never presented as valid.
- release_in[b] clears bank_valid[b] next edge; release of non-valid bank ignored; release and completion of same bank on same edge: completion wins (bank_valid=1). Release of other bank same edge both applied.
- Address arithmetic at AW+YW bits, truncated to AW only after range check.

Test Plan:
- Reset then fetch x=0,y=0, BRAM word=address: bank0 rows ch0 = 0,40,80,120,160,200; done_out pulse cycle 9, done_bank=0, bank_valid=01.
- Second fetch ch0 (x=1,y=1), ch1 (x=2,y=2) without release: lands in bank1 rows 41..241 / 82..282; bank0 unchanged; bank_valid=11, ready_out=0, valid_in ignored.
- release_in=01 then fetch: fills bank0; release_in=10 same edge as bank0 completion -> bank_valid=01.
- y=317, x=39: rows 0-2 = 12719,12759,12799; rows 3-5 zero. x=40: all rows zero.
- Assert rst_in mid-ISSUE (cycle 3): banks zero, bank_valid=00, no done_out, ready_out=1 after release.
- Re-run first case with BRAM_LATENCY=1, NUM_CH=3, BLOCK_SIZE=4: done_out in cycle 6, all three channels correct.
